// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encodings, branch codes and register constants for hazard_unit
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, MEMWAIT = 2'd2} state_t;
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BNE = 2'b01;
  localparam logic [1:0] BR_BEQ = 2'b11;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_perf_counters.sv
// hazard_perf_counters: three saturating event counters for the hazard unit
//   clk, rst_n                      clock, async active-low reset
//   stall_inc, flush_inc, freeze_inc one-cycle event strobes
//   stall_cycles, flush_count, freeze_cycles  counter values, hold at all-ones
module hazard_perf_counters #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc,
  input  logic             flush_inc,
  input  logic             freeze_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_cycles
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cycles  <= '0;
      flush_count   <= '0;
      freeze_cycles <= '0;
    end else begin
      stall_cycles  <= stall_cycles + CNT_W'(stall_inc & ~&stall_cycles);
      flush_count   <= flush_count + CNT_W'(flush_inc & ~&flush_count);
      freeze_cycles <= freeze_cycles + CNT_W'(freeze_inc & ~&freeze_cycles);
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, branch squash and memory-wait freeze sequencer
//   id_rs, id_rt, ex_memread, ex_rt   load-use detection inputs
//   ex_branch, ex_zero                branch resolution in EX
//   mem_req, mem_ready                data memory handshake
//   pc_write, if_id_write, controller_write, pc_src_branch,
//   if_id_flush, id_ex_flush, freeze  pipeline control outputs
//   stall_cycles, flush_count, freeze_cycles  only with HAZARD_PERF_CNT_EN
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic [1:0]       ex_branch,
  input  logic             ex_zero,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             controller_write,
  output logic             pc_src_branch,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             freeze
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_cycles
`endif
);
  localparam logic [3:0] LOAD_CNT = 4'(LOAD_STALL_CYCLES - 1);
  state_t state, ret_state;
  logic [3:0] cnt;
  logic wait_m, taken, hazard, flush, bubble, hold;
  always_comb begin
    wait_m = mem_req & ~mem_ready;
    taken = (ex_branch == BR_BEQ & ex_zero) | (ex_branch == BR_BNE & ~ex_zero);
    hazard = ex_memread & (ex_rt != REG_ZERO) & (ex_rt == id_rs | ex_rt == id_rt);
    // rst_n gates every output so reset shows idle values immediately
    freeze = rst_n & wait_m;
    flush = rst_n & ~wait_m & (state == RUN) & taken;
    bubble = rst_n & ~wait_m & (((state == RUN) & ~taken & hazard) | (state == STALL));
    hold = bubble | freeze | (rst_n & (state == MEMWAIT));
    pc_write = ~hold;
    if_id_write = ~hold;
    controller_write = bubble;
    pc_src_branch = flush;
    if_id_flush = flush;
    id_ex_flush = flush;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      ret_state <= RUN;
      cnt <= '0;
    end else begin
      case (state)
        RUN:
          if (wait_m) begin
            ret_state <= RUN;
            state <= MEMWAIT;
          end else if (!taken && hazard) begin
            cnt <= LOAD_CNT;
            state <= (LOAD_CNT != 4'd0) ? STALL : RUN;
          end
        STALL:
          if (wait_m) begin
            ret_state <= STALL;
            state <= MEMWAIT;
          end else begin
            // the last bubble is issued while cnt==1, so leave as it reaches 0
            cnt <= cnt - 4'd1;
            state <= (cnt <= 4'd1) ? RUN : STALL;
          end
        MEMWAIT: if (mem_ready) state <= ret_state;
        default: state <= RUN;
      endcase
    end
`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk(clk),
    .rst_n(rst_n),
    .stall_inc(controller_write),
    .flush_inc(flush),
    .freeze_inc(freeze),
    .stall_cycles(stall_cycles),
    .flush_count(flush_count),
    .freeze_cycles(freeze_cycles)
  );
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a bubble-debt model
module tb_hazard_unit;
  localparam int L = 2;
  localparam int CW = 4;
  logic clk = 0, rst_n = 0;
  logic [4:0] id_rs = 0, id_rt = 0, ex_rt = 0;
  logic ex_memread = 0, ex_zero = 0, mem_req = 0, mem_ready = 0;
  logic [1:0] ex_branch = 0;
  logic pc_write, if_id_write, controller_write, pc_src_branch, if_id_flush, id_ex_flush, freeze;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cycles, flush_count, freeze_cycles;
  hazard_unit #(.LOAD_STALL_CYCLES(L), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .ex_branch(ex_branch), .ex_zero(ex_zero), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_write(pc_write), .if_id_write(if_id_write),
    .controller_write(controller_write), .pc_src_branch(pc_src_branch),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .freeze(freeze),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .freeze_cycles(freeze_cycles));
`else
  hazard_unit #(.LOAD_STALL_CYCLES(L), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .ex_branch(ex_branch), .ex_zero(ex_zero), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_write(pc_write), .if_id_write(if_id_write),
    .controller_write(controller_write), .pc_src_branch(pc_src_branch),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .freeze(freeze));
`endif
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s got %0d expected %0d", name, got, exp);
  endtask
  task automatic clr();
    ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
    ex_branch = 0; ex_zero = 0; mem_req = 0; mem_ready = 0;
  endtask
  // Model: the pipe owes a number of bubbles; a memory wait suspends everything
  int owed = 0, cw_n = 0, fl_n = 0, fz_n = 0;
  bit frozen = 0;
  always begin
    int n_owed, e_pc, e_cw, e_fl, e_fz;
    bit n_frozen, wt, tk, hz;
    @(negedge clk);
    #2;
    wt = mem_req && !mem_ready;
    tk = (ex_branch == 2'b11 && ex_zero) || (ex_branch == 2'b01 && !ex_zero);
    hz = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    n_owed = owed; n_frozen = frozen;
    e_pc = 1; e_cw = 0; e_fl = 0; e_fz = wt;
    if (!rst_n) begin
      e_fz = 0;
    end else if (frozen) begin
      e_pc = 0;
      if (mem_ready) n_frozen = 0;
    end else if (wt) begin
      e_pc = 0; n_frozen = 1;
    end else if (owed > 0) begin
      e_pc = 0; e_cw = 1; n_owed = owed - 1;
    end else if (tk) begin
      e_fl = 1;
    end else if (hz) begin
      e_pc = 0; e_cw = 1; n_owed = L - 1;
    end
    chk("m_pc_write", pc_write, e_pc);
    chk("m_if_id_write", if_id_write, e_pc);
    chk("m_controller_write", controller_write, e_cw);
    chk("m_pc_src_branch", pc_src_branch, e_fl);
    chk("m_if_id_flush", if_id_flush, e_fl);
    chk("m_id_ex_flush", id_ex_flush, e_fl);
    chk("m_freeze", freeze, e_fz);
`ifdef HAZARD_PERF_CNT_EN
    chk("m_stall_cycles", stall_cycles, cw_n);
    chk("m_flush_count", flush_count, fl_n);
    chk("m_freeze_cycles", freeze_cycles, fz_n);
`endif
    @(posedge clk);
    if (!rst_n) begin
      owed = 0; frozen = 0; cw_n = 0; fl_n = 0; fz_n = 0;
    end else begin
      owed = n_owed; frozen = n_frozen;
      if (e_cw && cw_n < 15) cw_n++;
      if (e_fl && fl_n < 15) fl_n++;
      if (e_fz && fz_n < 15) fz_n++;
    end
  end
  task automatic cyc();
    @(negedge clk);
  endtask
  initial begin
    #1;
    chk("reset_pc_write", pc_write, 1);
    chk("reset_controller_write", controller_write, 0);
    cyc(); rst_n = 1;
    cyc(); ex_memread = 1; ex_rt = 8; id_rs = 8; #1;
    chk("lu_bubble1_pc", pc_write, 0); chk("lu_bubble1_cw", controller_write, 1);
    cyc(); clr(); #1;
    chk("lu_bubble2_pc", pc_write, 0); chk("lu_bubble2_cw", controller_write, 1);
    cyc(); #1;
    chk("lu_idle_pc", pc_write, 1); chk("lu_idle_cw", controller_write, 0);
    cyc(); ex_memread = 1; ex_rt = 0; id_rt = 0; #1;
    chk("zero_no_stall", controller_write, 0);
    cyc(); clr(); ex_memread = 1; ex_rt = 5; id_rt = 5; ex_branch = 2'b11; ex_zero = 1; #1;
    chk("beq_flush", pc_src_branch, 1); chk("beq_if_id_flush", if_id_flush, 1);
    chk("beq_no_stall", controller_write, 0);
    cyc(); clr(); #1;
    chk("beq_flush_one_cycle", pc_src_branch, 0); chk("beq_no_late_stall", controller_write, 0);
    cyc(); ex_branch = 2'b01; ex_zero = 1; #1;
    chk("bne_no_flush", id_ex_flush, 0);
    cyc(); clr(); ex_memread = 1; ex_rt = 3; id_rs = 3; #1;
    chk("mw_bubble1", controller_write, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); clr(); mem_req = 1; #1;
      chk("mw_freeze", freeze, 1); chk("mw_no_bubble", controller_write, 0);
    end
    cyc(); mem_ready = 1; #1;
    chk("mw_release_freeze", freeze, 0); chk("mw_release_pc", pc_write, 0);
    cyc(); clr(); #1;
    chk("mw_bubble2", controller_write, 1);
    cyc(); #1;
    chk("mw_done", controller_write, 0);
    cyc(); ex_memread = 1; ex_rt = 9; id_rt = 9;
    cyc(); clr(); rst_n = 0; #1;
    chk("rst_mid_pc", pc_write, 1); chk("rst_mid_cw", controller_write, 0);
    cyc(); rst_n = 1; #1;
    chk("rst_after_cw", controller_write, 0); chk("rst_after_pc", pc_write, 1);
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst_n = ($urandom_range(0, 99) != 0);
      ex_memread = $urandom_range(0, 1);
      ex_rt = 5'($urandom_range(0, 3));
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_branch = 2'($urandom_range(0, 3));
      ex_zero = $urandom_range(0, 1);
      mem_req = ($urandom_range(0, 9) < 3);
      mem_ready = $urandom_range(0, 1);
    end
    cyc(); clr(); rst_n = 0;
    cyc(); rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(); ex_memread = 1; ex_rt = 7; id_rs = 7;
    end
    cyc(); clr(); #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt_saturated", stall_cycles, 15);
`endif
    chk("final_idle", pc_write, 1);
    cyc(); cyc();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
